// File: rtl/bin_to_bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin_to_bcd_converter                                                     |
// | Sequential double-dabble converter: binary in, packed BCD out, with a    |
// | start/busy/done handshake. Define BCD_AUTO_REFRESH_EN for free-running   |
// | reconversion of i_value (i_start then ignored).                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bin_to_bcd_converter #(
  parameter int DATA_W = 27,
  parameter int DIGITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_W-1:0]     i_value,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow
);

  localparam int          c_scratch_w = 4*DIGITS + 4;
  localparam int          c_count_w   = $clog2(DATA_W) + 1;
  localparam logic [c_count_w-1:0] c_last = c_count_w'(DATA_W - 1);
  localparam logic [31:0] c_limit     = 10**DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DATA_W-1:0]      r_bin;
  logic [c_scratch_w-1:0] r_scratch;
  logic [c_count_w-1:0]   r_count;
  logic                   r_ovf_pend;
  logic                   r_done;
  logic [4*DIGITS-1:0]    r_bcd;
  logic                   r_ovf;
  logic                   w_start;
  logic [31:0]            w_value_ext;
  logic [c_scratch_w-2:0] w_adj;

`ifdef BCD_AUTO_REFRESH_EN
  assign w_start = 1'b1;
`else
  assign w_start = i_start;
`endif

  assign w_value_ext = 32'(i_value);

  // Add-3 correction on every full digit; the guard nibble only needs its low 3 bits.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                r_scratch[4*gi +: 4] + 4'd3 : r_scratch[4*gi +: 4];
    end
  endgenerate

  assign w_adj[c_scratch_w-2 -: 3] = (r_scratch[c_scratch_w-1 -: 4] >= 4'd5) ?
                                     r_scratch[c_scratch_w-2 -: 3] + 3'd3 :
                                     r_scratch[c_scratch_w-2 -: 3];

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_next = ST_SHIFT;
      ST_SHIFT: if (r_count == c_last) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bin      <= '0;
      r_scratch  <= '0;
      r_count    <= '0;
      r_ovf_pend <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bin      <= i_value;
            r_scratch  <= '0;
            r_count    <= '0;
            r_ovf_pend <= (w_value_ext >= c_limit);
          end
        end
        ST_SHIFT: begin
          r_scratch <= {w_adj, r_bin[DATA_W-1]};
          r_bin     <= r_bin << 1;
          r_count   <= r_count + 1'b1;
        end
        ST_DONE: begin
          // Overflow saturates the display instead of showing truncated digits.
          r_bcd  <= r_ovf_pend ? {DIGITS{4'h9}} : r_scratch[4*DIGITS-1:0];
          r_ovf  <= r_ovf_pend;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_bcd      = r_bcd;
  assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bin_to_bcd_converter                                                  |
// | Directed self-checking bench for bin_to_bcd_converter (DATA_W=27, 8 dig).|
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bin_to_bcd_converter;

  logic        clk;
  logic        rst;
  logic [26:0] value;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;

  int n_assert = 0;
  int n_fail   = 0;

  bin_to_bcd_converter #(.DATA_W(27), .DIGITS(8)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_value    (value),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_bcd      (bcd),
    .o_overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from the current sample point to the next o_done; -1 if none within 60.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic convert(input logic [26:0] v, input logic [31:0] exp_bcd,
                         input logic exp_ovf, input string tag);
    int lat;
    value = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, busy, 1);
    wait_done(lat);
    check({tag, " latency"}, lat, 28);
    check({tag, " bcd"}, bcd, exp_bcd);
    check({tag, " ovf"}, ovf, exp_ovf);
  endtask

  initial begin
    int lat;
    int dones;
    int busy_seen;
    rst   = 1'b1;
    value = '0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

`ifdef BCD_AUTO_REFRESH_EN
    value = 27'd31;
    rst   = 1'b0;
    wait_done(lat);
    check("auto first done", (lat > 0), 1);
    wait_done(lat);
    check("auto period 31", lat, 29);
    check("auto bcd 31", bcd, 32'h00000031);
    value = 27'd2024;
    wait_done(lat);
    check("auto period 2024", lat, 29);
    check("auto bcd 2024", bcd, 32'h00002024);
    wait_done(lat);
    check("auto period steady", lat, 29);
    check("auto bcd steady", bcd, 32'h00002024);
    check("auto ovf", ovf, 0);
`else
    rst = 1'b0;
    dones = 0;
    busy_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (busy) busy_seen++;
    end
    check("idle done count", dones, 0);
    check("idle busy count", busy_seen, 0);
    check("reset bcd", bcd, 0);
    check("reset ovf", ovf, 0);

    convert(27'd12345678, 32'h12345678, 1'b0, "12345678");
    convert(27'd99999999, 32'h99999999, 1'b0, "99999999");
    convert(27'd0,        32'h00000000, 1'b0, "zero");

    // Start 42, then hammer i_start/i_value during the conversion.
    value = 27'd42;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k >= 3 && k <= 10) begin
        start = 1'b1;
        value = 27'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (lat < 0) lat = k;
      end
    end
    start = 1'b0;
    check("ignore start done count", dones, 1);
    check("ignore start latency", lat, 28);
    check("ignore start bcd", bcd, 32'h00000042);

    convert(27'd134217727, 32'h99999999, 1'b1, "max27");
    convert(27'd100000000, 32'h99999999, 1'b1, "1e8");

    // Abort a conversion of 555 with reset partway through.
    value = 27'd555;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midconv bcd held", bcd, 32'h99999999);
    check("midconv busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort bcd", bcd, 0);
    check("abort ovf", ovf, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort no done", dones, 0);
    convert(27'd9, 32'h00000009, 1'b0, "after abort");
    @(posedge clk); #1;
    check("done pulse width", done, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
